// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared CPU constants, next-PC select encoding and PC helpers.
package fetch_stage_pkg;
  localparam logic [31:0] PC_RESET = 32'h0000_3000;
  localparam logic [31:0] IM_LAST  = 32'h0000_6FFC;
  localparam logic [31:0] NOP      = 32'h0000_0000;
  typedef enum logic [1:0] {SEL_SEQ, SEL_BR, SEL_J, SEL_JR} npc_sel_e;
  function automatic logic [31:0] br_target(input logic [31:0] pc, input logic [15:0] imm);
    return pc + 32'd4 + {{14{imm[15]}}, imm, 2'b00};
  endfunction
  function automatic logic [31:0] j_target(input logic [31:0] pc, input logic [25:0] idx);
    return {pc[31:28], idx, 2'b00};
  endfunction
endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: control, instruction-memory and IF/ID signals of the fetch stage.
interface fetch_stage_if;
  logic        Stall;
  logic        Clr_D;
  logic        Br_Taken_D;
  logic        Jump_D;
  logic        JR_D;
  logic [31:0] RS_Data_D;
  logic [31:0] IM_Addr;
  logic [31:0] IM_Rdata;
  logic [31:0] Instr_D;
  logic [31:0] PC_D;
  logic [31:0] PC8_D;
  logic        Valid_D;
  logic        AdEL_D;
  modport master (
    output Stall, Clr_D, Br_Taken_D, Jump_D, JR_D, RS_Data_D, IM_Rdata,
    input  IM_Addr, Instr_D, PC_D, PC8_D, Valid_D, AdEL_D
  );
  modport slave (
    input  Stall, Clr_D, Br_Taken_D, Jump_D, JR_D, RS_Data_D, IM_Rdata,
    output IM_Addr, Instr_D, PC_D, PC8_D, Valid_D, AdEL_D
  );
endinterface

// File: rtl/fetch_stage_npc.sv
// npc: combinational next-PC mux; redirects only count when the D-stage instruction is valid.
module npc
  import fetch_stage_pkg::*;
(
  input  logic        i_valid,
  input  logic        i_jr,
  input  logic        i_jump,
  input  logic        i_br,
  input  logic [31:0] i_rs,
  input  logic [25:0] i_index,
  input  logic [31:0] i_pc_d,
  input  logic [31:0] i_pc_f,
  output logic [31:0] o_npc
);
  npc_sel_e w_sel;
  always_comb begin
    w_sel = !i_valid ? SEL_SEQ : i_jr ? SEL_JR : i_jump ? SEL_J : i_br ? SEL_BR : SEL_SEQ;
    o_npc = w_sel == SEL_JR ? i_rs
          : w_sel == SEL_J  ? j_target(i_pc_d, i_index)
          : w_sel == SEL_BR ? br_target(i_pc_d, i_index[15:0])
          : i_pc_f + 32'd4;
  end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC register and IF/ID pipeline register with delayed-branch redirect,
// stall/bubble control and illegal-fetch-address detection.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] PC_RESET = fetch_stage_pkg::PC_RESET,
  parameter logic [31:0] IM_LAST  = fetch_stage_pkg::IM_LAST
) (
  input logic         clk,
  input logic         reset,
  fetch_stage_if.slave bus
);
  logic [31:0] r_pc_f;
  logic [31:0] r_instr_d;
  logic [31:0] r_pc_d;
  logic        r_valid_d;
  logic        r_adel_d;
  logic [31:0] w_npc;
  logic        w_legal;
  npc u_npc (
    .i_valid (r_valid_d),
    .i_jr    (bus.JR_D),
    .i_jump  (bus.Jump_D),
    .i_br    (bus.Br_Taken_D),
    .i_rs    (bus.RS_Data_D),
    .i_index (r_instr_d[25:0]),
    .i_pc_d  (r_pc_d),
    .i_pc_f  (r_pc_f),
    .o_npc   (w_npc)
  );
  assign w_legal = (r_pc_f[1:0] == 2'b00) && (r_pc_f >= PC_RESET) && (r_pc_f <= IM_LAST);
  // Stall freezes everything, so it wins over both the bubble and any redirect.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc_f    <= PC_RESET;
      r_instr_d <= NOP;
      r_pc_d    <= PC_RESET;
      r_valid_d <= 1'b0;
      r_adel_d  <= 1'b0;
    end else if (!bus.Stall) begin
      r_pc_f    <= w_npc;
      r_pc_d    <= r_pc_f;
      r_valid_d <= !bus.Clr_D;
      r_adel_d  <= !bus.Clr_D && !w_legal;
      r_instr_d <= (bus.Clr_D || !w_legal) ? NOP : bus.IM_Rdata;
    end
  end
  assign bus.IM_Addr = r_pc_f;
  assign bus.Instr_D = r_instr_d;
  assign bus.PC_D    = r_pc_d;
  assign bus.PC8_D   = r_pc_d + 32'd8;
  assign bus.Valid_D = r_valid_d;
  assign bus.AdEL_D  = r_adel_d;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed-vector bench for fetch_stage with a small combinational instruction memory.
module tb_fetch_stage;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  logic [97:0] exp;
  logic [97:0] obs;
  fetch_stage_if f();
  fetch_stage dut (.clk(clk), .reset(reset), .bus(f.slave));
  always #5 clk = ~clk;
  function automatic logic [31:0] imem(input logic [31:0] a);
    return a == 32'h3010 ? 32'h1000_FFFC : a == 32'h3020 ? 32'h0800_0C10 : (32'hA000_0000 | a);
  endfunction
  assign f.IM_Rdata = imem(f.IM_Addr);
  assign obs = {f.IM_Addr, f.Instr_D, f.PC_D, f.Valid_D, f.AdEL_D};
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    tick;
    exp = {32'h3000, 32'h0, 32'h3000, 2'b00};
    n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL reset obs=%h exp=%h", obs, exp); end
    n_cmp++; if (f.PC8_D !== 32'h3008) begin n_bad++; $display("FAIL reset_pc8 obs=%h exp=3008", f.PC8_D); end
    reset = 1'b1;
  endtask
  task automatic test_sequential;
    tick; exp = {32'h3004, 32'hA000_3000, 32'h3000, 2'b10};
    n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL seq0 obs=%h exp=%h", obs, exp); end
    tick; exp = {32'h3008, 32'hA000_3004, 32'h3004, 2'b10};
    n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL seq1 obs=%h exp=%h", obs, exp); end
    tick; exp = {32'h300C, 32'hA000_3008, 32'h3008, 2'b10};
    n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL seq2 obs=%h exp=%h", obs, exp); end
  endtask
  task automatic test_branch;
    tick; exp = {32'h3010, 32'hA000_300C, 32'h300C, 2'b10};
    n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL br_pre obs=%h exp=%h", obs, exp); end
    tick; exp = {32'h3014, 32'h1000_FFFC, 32'h3010, 2'b10};
    n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL br_in_d obs=%h exp=%h", obs, exp); end
    f.Br_Taken_D = 1'b1;
    tick; exp = {32'h3004, 32'hA000_3014, 32'h3014, 2'b10};
    n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL br_slot obs=%h exp=%h", obs, exp); end
    f.Br_Taken_D = 1'b0;
  endtask
  task automatic test_stall;
    repeat (4) tick;
    exp = {32'h3014, 32'h1000_FFFC, 32'h3010, 2'b10};
    n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL st_pre obs=%h exp=%h", obs, exp); end
    f.Stall = 1'b1; f.Clr_D = 1'b1; f.Br_Taken_D = 1'b1;
    tick;
    n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL st_hold0 obs=%h exp=%h", obs, exp); end
    tick;
    n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL st_hold1 obs=%h exp=%h", obs, exp); end
    f.Stall = 1'b0; f.Clr_D = 1'b0;
    tick; exp = {32'h3004, 32'hA000_3014, 32'h3014, 2'b10};
    n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL st_release obs=%h exp=%h", obs, exp); end
    f.Br_Taken_D = 1'b0;
  endtask
  task automatic test_jr_illegal;
    f.JR_D = 1'b1; f.RS_Data_D = 32'h3002;
    tick; exp = {32'h3002, 32'hA000_3004, 32'h3004, 2'b10};
    n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL jr_slot obs=%h exp=%h", obs, exp); end
    f.JR_D = 1'b0;
    tick; exp = {32'h3006, 32'h0, 32'h3002, 2'b11};
    n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL jr_misalign obs=%h exp=%h", obs, exp); end
    f.JR_D = 1'b1; f.RS_Data_D = 32'h7000;
    tick; exp = {32'h7000, 32'h0, 32'h3006, 2'b11};
    n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL jr_7000_slot obs=%h exp=%h", obs, exp); end
    f.JR_D = 1'b0;
    tick; exp = {32'h7004, 32'h0, 32'h7000, 2'b11};
    n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL jr_above obs=%h exp=%h", obs, exp); end
    f.JR_D = 1'b1; f.RS_Data_D = 32'h6FFC;
    tick; exp = {32'h6FFC, 32'h0, 32'h7004, 2'b11};
    n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL jr_last_slot obs=%h exp=%h", obs, exp); end
    f.JR_D = 1'b0;
    tick; exp = {32'h7000, 32'hA000_6FFC, 32'h6FFC, 2'b10};
    n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL jr_last_legal obs=%h exp=%h", obs, exp); end
    f.JR_D = 1'b1; f.RS_Data_D = 32'h2FFC;
    tick; exp = {32'h2FFC, 32'h0, 32'h7000, 2'b11};
    n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL jr_low_slot obs=%h exp=%h", obs, exp); end
    f.JR_D = 1'b0;
    tick; exp = {32'h3000, 32'h0, 32'h2FFC, 2'b11};
    n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL jr_below obs=%h exp=%h", obs, exp); end
  endtask
  task automatic test_clear;
    f.Clr_D = 1'b1;
    tick; exp = {32'h3004, 32'h0, 32'h3000, 2'b00};
    n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL clr_bubble obs=%h exp=%h", obs, exp); end
    f.Clr_D = 1'b0; f.Jump_D = 1'b1;
    tick; exp = {32'h3008, 32'hA000_3004, 32'h3004, 2'b10};
    n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL clr_no_redirect obs=%h exp=%h", obs, exp); end
    f.Jump_D = 1'b0;
  endtask
  task automatic test_jump;
    f.JR_D = 1'b1; f.RS_Data_D = 32'h3020;
    tick; exp = {32'h3020, 32'hA000_3008, 32'h3008, 2'b10};
    n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL j_setup obs=%h exp=%h", obs, exp); end
    f.JR_D = 1'b0;
    tick; exp = {32'h3024, 32'h0800_0C10, 32'h3020, 2'b10};
    n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL j_in_d obs=%h exp=%h", obs, exp); end
    n_cmp++; if (f.PC8_D !== 32'h3028) begin n_bad++; $display("FAIL j_pc8 obs=%h exp=3028", f.PC8_D); end
    f.Jump_D = 1'b1;
    tick; exp = {32'h3040, 32'hA000_3024, 32'h3024, 2'b10};
    n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL j_slot obs=%h exp=%h", obs, exp); end
    f.Jump_D = 1'b0;
    tick; exp = {32'h3044, 32'hA000_3040, 32'h3040, 2'b10};
    n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL j_target obs=%h exp=%h", obs, exp); end
  endtask
  task automatic test_async_reset;
    f.JR_D = 1'b1; f.RS_Data_D = 32'h3500;
    #2 reset = 1'b0;
    #1 exp = {32'h3000, 32'h0, 32'h3000, 2'b00};
    n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL ar_immediate obs=%h exp=%h", obs, exp); end
    tick;
    n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL ar_held obs=%h exp=%h", obs, exp); end
    f.JR_D = 1'b0;
    reset = 1'b1;
    tick; exp = {32'h3004, 32'hA000_3000, 32'h3000, 2'b10};
    n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL ar_restart obs=%h exp=%h", obs, exp); end
  endtask
  initial begin
    f.Stall = 1'b0; f.Clr_D = 1'b0; f.Br_Taken_D = 1'b0;
    f.Jump_D = 1'b0; f.JR_D = 1'b0; f.RS_Data_D = 32'h0;
    test_reset;
    test_sequential;
    test_branch;
    test_stall;
    test_jr_illegal;
    test_clear;
    test_jump;
    test_async_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL parameter PC_RESET, default 32'h0000_3000, meaning reset value of the fetch PC.
REQ-002 SHALL parameter IM_LAST, default 32'h0000_6FFC, meaning highest legal instruction word address.
REQ-003 SHALL port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL port Stall  input  1  hazard stall; holds the PC and the IF/ID register.
REQ-006 SHALL port Clr_D  input  1  loads a bubble into the IF/ID register.
REQ-007 SHALL port Br_Taken_D  input  1  the D-stage comparator resolved the branch in Instr_D as taken.
REQ-008 SHALL port Jump_D  input  1  Instr_D is j/jal.
REQ-009 SHALL port JR_D  input  1  Instr_D is jr/jalr.
REQ-010 SHALL port RS_Data_D  input  32  forwarded rs value, the jr target.
REQ-011 SHALL port IM_Addr  output  32  instruction memory address, equal to PC_F.
REQ-012 SHALL port IM_Rdata  input  32  combinational instruction memory read data.
REQ-013 SHALL port Instr_D  output  32  registered instruction; feeds the branch-compare decoder and main decoder.
REQ-014 SHALL port PC_D  output  32  registered PC of Instr_D.
REQ-015 SHALL port PC8_D  output  32  PC_D + 8, the link address.
REQ-016 SHALL port Valid_D  output  1  Instr_D holds a real fetched instruction.
REQ-017 SHALL port AdEL_D  output  1  Instr_D was fetched from an illegal address.

Function
REQ-018 SHALL hold PC_F as a 32-bit register; IM_Addr = PC_F combinationally.
REQ-019 SHALL compute NPC with priority: JR_D -> RS_Data_D; else Jump_D -> {PC_D[31:28], Instr_D[25:0], 2'b00}; else Br_Taken_D -> PC_D + 4 + (sign-extend(Instr_D[15:0]) << 2); else PC_F + 4.
REQ-020 SHALL use modulo-2^32 arithmetic for all PC math, with no overflow trap.
REQ-021 SHALL implement delayed-branch semantics: the instruction in IF when a redirect is asserted is the delay slot and enters ID normally; no flush on redirect.
REQ-022 SHALL, when Stall=1, hold PC_F, Instr_D, PC_D, Valid_D and AdEL_D; Stall overrides Clr_D and any redirect.
REQ-023 SHALL, when Stall=0 and Clr_D=1, load Instr_D=0 (nop), Valid_D=0, AdEL_D=0 and PC_D=PC_F, and advance PC_F to NPC.
REQ-024 SHALL, when Stall=0 and Clr_D=0, load Instr_D=IM_Rdata, PC_D=PC_F, Valid_D=1, and set PC_F to NPC.
REQ-025 SHALL treat PC_F as illegal when PC_F[1:0]!=0, PC_F<PC_RESET or PC_F>IM_LAST; an illegal fetch loads Instr_D=0 and AdEL_D=1, with Valid_D=1.
REQ-026 SHALL qualify redirects with Valid_D: when Valid_D=0, Br_Taken_D, Jump_D and JR_D are ignored.
REQ-027 SHALL make PC8_D combinational from PC_D, with 1-cycle fetch-to-decode latency.

Reset
REQ-028 SHALL, while reset=0 and asynchronously, set PC_F=PC_RESET, Instr_D=0, PC_D=PC_RESET, Valid_D=0 and AdEL_D=0.
REQ-029 SHALL fetch PC_RESET on the first edge after reset deasserts; reset mid-stall or mid-redirect discards the pending redirect.

Structure
REQ-030 SHALL place PC_RESET, IM_LAST and the NOP constant (32'h0) in the shared CPU constants package.
REQ-031 SHALL contain one sub-module, npc, that holds the combinational next-PC mux of REQ-019; the registers stay in fetch_stage.

Verification
REQ-032 SHALL cover: reset release, then 3 edges with no stall -> IM_Addr 3000, 3004, 3008, 300C; Instr_D tracks IM_Rdata one cycle late.
REQ-033 SHALL cover: beq at 3010 with offset 16'hFFFC and Br_Taken_D=1 -> delay slot at 3014 decoded, next fetch at 3004.
REQ-034 SHALL cover: Stall=1 for 2 cycles with Br_Taken_D=1 and Clr_D=1 -> PC_F and Instr_D unchanged; redirect applied on the first unstalled edge.
REQ-035 SHALL cover: jr with RS_Data_D=32'h3002 -> next fetch gives Instr_D=0, AdEL_D=1; RS_Data_D=7000 also gives AdEL_D=1.
REQ-036 SHALL cover: j with index 26'h0000C10 at PC_D=3020 -> PC_F=3040 after the delay slot; PC8_D=3028 while j is in D.
REQ-037 SHALL cover: reset asserted mid-cycle during a JR redirect -> outputs go to reset values immediately, with no clock edge needed.
